// File: rtl/conv_result_collector.sv
// Result collector for the convolve datapath: tracks frame position, drops row-wrap
// window positions and buffers surviving pixels in a registered-output FWFT FIFO.
module conv_result_collector #(
    parameter int BITS        = 9,
    parameter int IMG_LENGTH  = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BITS-1:0]  pixel_in,
    input  logic             pixel_valid,
    output logic [BITS-1:0]  pixel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic             busy,
    output logic             frame_done
);

    localparam int OUT_ROWS = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int LAST_COL = IMG_LENGTH - KERNEL_SIZE;
    localparam int COL_W    = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] next_rd;
    logic [LVL_W-1:0] next_level;
    logic [BITS-1:0]  head_next;
    logic             beat;
    logic             keep;
    logic             full;
    logic             pop;
    logic             push;
    logic             last_beat;
    logic             last_col;

    assign out_valid  = (fifo_level != '0);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_FLUSH) && (fifo_level == '0);

    assign beat      = (state == S_RUN) && pixel_valid;
    assign keep      = beat && (col <= COL_W'(LAST_COL));
    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = keep && (!full || pop);
    assign last_col  = (col == COL_W'(IMG_LENGTH - 1));
    assign last_beat = beat && last_col && (row == ROW_W'(OUT_ROWS - 1));
    assign next_rd   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        next_level = fifo_level;
        case ({push, pop})
            2'b10:   next_level = fifo_level + LVL_W'(1);
            2'b01:   next_level = fifo_level - LVL_W'(1);
            default: next_level = fifo_level;
        endcase
    end

    // Next head: bypass pixel_in when the entry being written becomes the head.
    always_comb begin
        head_next = pixel_out;
        if (next_level != '0) begin
            if (fifo_level == '0 || (pop && fifo_level == LVL_W'(1)))
                head_next = pixel_in;
            else
                head_next = mem[next_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pixel_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pixel_out  <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (beat) begin
                        if (last_beat) begin
                            state <= S_FLUSH;
                            row   <= '0;
                            col   <= '0;
                        end else if (last_col) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (frame_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr     <= next_rd;
            fifo_level <= next_level;
            pixel_out  <= head_next;
            if (keep && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: a queue of expected FIFO contents is
// advanced alongside the DUT and every sample is checked with immediate assertions.
module tb_conv_result_collector;

    localparam int BITS  = 9;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BITS-1:0]  pixel_in;
    logic             pixel_valid;
    logic [BITS-1:0]  pixel_out;
    logic             out_valid;
    logic             out_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             busy;
    logic             frame_done;

    logic [BITS-1:0] exp_q[$];
    logic            exp_ovf;
    int              checks;
    int              fails;
    int              pops;
    int              done_cnt;

    conv_result_collector dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_out   (pixel_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check the current outputs against the model, then clock the inputs in.
    task automatic step(input logic pv, input logic [BITS-1:0] val, input logic kept);
        pixel_valid = pv;
        pixel_in    = val;
        chk("level", 32'(fifo_level), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
                chk("pop_data", 32'(pixel_out), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            pops++;
        end
        if (kept) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(val);
            else exp_ovf = 1'b1;
        end
        if (frame_done) done_cnt++;
        @(posedge clk);
        #1;
        chk("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pixel_valid = 1'b1;
        start       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        pixel_valid = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1'b0, '0, 1'b0);
        start = 1'b0;
    endtask

    // Full frame of 224 beats, then flush until idle; values are (base + index) mod 512.
    task automatic run_frame(input int base);
        int n;
        pops     = 0;
        done_cnt = 0;
        for (int i = 0; i < 224; i++)
            step(1'b1, BITS'((base + i) % 512), (i % 16) <= 13);
        n = 0;
        while (busy && n < 40) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk("frame_pops", 32'(pops), 32'd196);
        chk("frame_done_cnt", 32'(done_cnt), 32'd1);
        chk("frame_busy_end", 32'(busy), 32'd0);
        chk("frame_done_low", 32'(frame_done), 32'd0);
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        pops      = 0;
        done_cnt  = 0;
        exp_ovf   = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        pixel_in  = 9'h1ff;
        out_ready = 1'b1;

        // 1: reset with pixel_valid high, then beats without start
        do_reset();
        chk("rst_pixel_out", 32'(pixel_out), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, BITS'(i + 1), 1'b0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 2: full frame with continuous drain
        out_ready = 1'b1;
        pulse_start();
        chk("t2_busy", 32'(busy), 32'd1);
        run_frame(0);

        // 3: back-pressure until overflow, then drain
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, BITS'(100 + i), 1'b1);
            if (i == 7) begin
                chk("t3_level8", 32'(fifo_level), 32'd8);
                chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
            end
            if (i == 8) chk("t3_ovf", 32'(overflow), 32'd1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
        chk("t3_drained", 32'(fifo_level), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) step(1'b1, BITS'(200 + i), 1'b1);
        chk("t4_full", 32'(fifo_level), 32'd8);
        out_ready = 1'b1;
        for (int i = 8; i < 14; i++) begin
            chk("t4_level_held", 32'(fifo_level), 32'd8);
            step(1'b1, BITS'(200 + i), 1'b1);
        end
        chk("t4_level_after", 32'(fifo_level), 32'd8);
        chk("t4_no_ovf", 32'(overflow), 32'd0);
        step(1'b1, BITS'(214), 1'b0);
        step(1'b1, BITS'(215), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);

        // 5: single push into an empty FIFO
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        step(1'b1, 9'h155, 1'b1);
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_data", 32'(pixel_out), 32'h155);
        step(1'b0, '0, 1'b0);
        chk("t5_empty", 32'(out_valid), 32'd0);
        chk("t5_hold", 32'(pixel_out), 32'h155);

        // 6: reset mid-frame, then a clean frame
        do_reset();
        pulse_start();
        for (int i = 0; i < 50; i++) step(1'b1, BITS'(300 + i), (i % 16) <= 13);
        reset = 1'b1;
        pixel_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pixel_valid = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        pulse_start();
        run_frame(37);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
Downstream stage of the convolve datapath. It consumes the raw per-cycle pixel stream from the multiplier output and tracks row/column position within the frame. It discards the window positions that wrap across an image row. Surviving result pixels are buffered in a small first-word-fall-through FIFO with a valid/ready read port, so the management SoC or I/O logic can drain results at its own pace.

Parameters:
BITS, 9, pixel width (matches convolve BITS)
IMG_LENGTH, 16, input image row length in pixels
IMG_HEIGHT, 16, input image row count
KERNEL_SIZE, 3, kernel edge length; valid output columns = IMG_LENGTH-KERNEL_SIZE+1
FIFO_DEPTH, 8, result FIFO entries; power of two, >=2
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; arms collection of one frame
pixel_in  input  BITS  result pixel from the convolve stage
pixel_valid  input  1  pixel_in carries a result this cycle (convolve out_en delayed to match pixel_out)
pixel_out  output  BITS  head-of-FIFO pixel
out_valid  output  1  FIFO non-empty; pixel_out is valid
out_ready  input  1  consumer accepts pixel_out this cycle
fifo_level  output  LVL_W  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky; a kept pixel was dropped because the FIFO was full
busy  output  1  state != IDLE
frame_done  output  1  one-cycle pulse when a frame is fully collected and drained

Behaviour:
- Reset: state=IDLE; row=0, col=0; FIFO empty; pixel_out=0, out_valid=0, fifo_level=0, overflow=0, busy=0, frame_done=0. Reset mid-frame aborts the frame and discards FIFO contents.
- Derived constants: OUT_ROWS = IMG_HEIGHT-KERNEL_SIZE+1; LAST_COL = IMG_LENGTH-KERNEL_SIZE; beats per frame = OUT_ROWS*IMG_LENGTH (224 at defaults).
- FSM:
  - IDLE: pixel_valid is ignored. start -> RUN.
  - RUN: each cycle with pixel_valid=1 is one beat at the current (row, col).
    - col advances 0..IMG_LENGTH-1 and then wraps to 0, incrementing row.
    - A beat is kept (pushed) iff col <= LAST_COL; otherwise it is discarded with no other effect.
    - The beat at (OUT_ROWS-1, IMG_LENGTH-1) moves to FLUSH. row and col return to 0 on the same edge.
    - start in RUN is ignored.
  - FLUSH: pixel_valid is ignored. When the FIFO is empty (fifo_level==0, no push pending), frame_done=1 for exactly one cycle and the FSM enters IDLE on the same edge.
  - start arriving in the same cycle as frame_done is ignored.
- FIFO push/pop (FWFT):
  - out_valid = (fifo_level != 0). pixel_out is the oldest entry, registered.
  - Pop occurs when out_valid & out_ready. Push occurs when a beat is kept.
  - Push latency: a pixel pushed in cycle N is visible on pixel_out/out_valid in cycle N+1.
  - Empty + push: no pop that cycle; level goes 0->1.
  - Full + push + pop: both occur; level stays FIFO_DEPTH; no overflow.
  - Full + push, no pop: the pixel is dropped, overflow=1 (held until reset), and col/row still advance.
  - Pop with empty FIFO is impossible because out_valid=0. out_ready is don't-care while out_valid=0.
  - When the FIFO is empty, pixel_out holds its last value. It is 0 after reset.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. fifo_level changes by +1, -1 or 0 per cycle.
- Pixel data is passed unmodified. No arithmetic is done on pixel values.

Test Plan:
1. Assert reset for 2 cycles with pixel_valid=1 -> all outputs 0 and FSM in IDLE. Deassert reset, drive 5 pixel_valid beats without start -> fifo_level stays 0 and busy=0.
2. Defaults, out_ready=1, pulse start, then 224 consecutive beats with pixel_in = beat index mod 512:
   - exactly 196 pops occur, in order 0..13, 16..29, ..., 208..221;
   - values with col 14 or 15 never appear;
   - frame_done pulses once after the last pop, then busy=0.
3. out_ready=0, start, 14 beats of values 100..113 -> fifo_level=8 after 8 kept beats, overflow=1 from the 9th kept beat. Then raise out_ready -> pops 100..107 in order, and overflow remains 1.
4. Fill the FIFO to 8, then hold out_ready=1 while kept beats continue each cycle -> fifo_level stays 8, overflow stays 0, and output order is preserved.
5. Empty FIFO with one push -> out_valid rises exactly one cycle after the push cycle, and pixel_out equals the pushed value.
6. Assert reset after 50 beats of a frame -> next cycle: fifo_level=0, out_valid=0, busy=0, no frame_done. Then start plus a full 224-beat frame -> 196 correct outputs, as in test 2.
